// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, forwarding selects and the
// in-flight scoreboard entry used by the hazard controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       wr;
    logic       load;
    logic [4:0] rs;
    logic [4:0] rt;
  } sb_entry_t;

  // An all-zero entry also zeroes rs/rt, so a bubble can never match a producer.
  localparam sb_entry_t SB_EMPTY = '0;

  function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] r);
    return e.valid && e.wr && (e.dst == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input sb_entry_t mem_e,
                                         input sb_entry_t wb_e,
                                         input logic [4:0] r);
    if (sb_hit(mem_e, r)) return FWD_EXMEM;
    if (sb_hit(wb_e, r))  return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scheduler_src_decode.sv
// Extracts source register fields from the IF/ID instruction and flags which
// of them the instruction actually reads.
module src_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic        use_rs,
  output logic        use_rt
);

  logic [5:0] opcode;
  logic       unused_imm;

  assign opcode     = instr[31:26];
  assign rs         = instr[25:21];
  assign rt         = instr[20:16];
  assign unused_imm = ^instr[15:0];

  assign use_rs = 1'b1;
  assign use_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);

endmodule

// File: rtl/hazard_scheduler.sv
// Hazard controller beside ID: tracks EX/MEM/WB producers and drives stalls,
// bubbles, branch flushes and EX-stage forwarding selects.
module hazard_scheduler
  import mips_pkg::*;
#(
  parameter bit FORWARDING = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_id,
  input  logic [4:0]       dst_id,
  input  logic             regwrite_id,
  input  logic             memread_id,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       use_rs;
  logic       use_rt;

  sb_entry_t  ex_q,  ex_d;
  sb_entry_t  mem_q, mem_d;
  sb_entry_t  wb_q,  wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic raw_hazard;
  logic stall;
  logic unused_sb;

  src_decode u_src_decode (
    .instr  (instr_id),
    .rs     (rs_id),
    .rt     (rt_id),
    .use_rs (use_rs),
    .use_rt (use_rt)
  );

  // WB only ever supplies its destination; its source fields are dead.
  assign unused_sb = ^{wb_q.load, wb_q.rs, wb_q.rt};

  if (FORWARDING) begin : g_fwd
    assign raw_hazard = ex_q.load &&
                        ((use_rs && sb_hit(ex_q, rs_id)) || (use_rt && sb_hit(ex_q, rt_id)));
    assign fwd_a = fwd_sel(mem_q, wb_q, ex_q.rs);
    assign fwd_b = fwd_sel(mem_q, wb_q, ex_q.rt);
  end else begin : g_nofwd
    assign raw_hazard =
      (use_rs && (sb_hit(ex_q, rs_id) || sb_hit(mem_q, rs_id) || sb_hit(wb_q, rs_id))) ||
      (use_rt && (sb_hit(ex_q, rt_id) || sb_hit(mem_q, rt_id) || sb_hit(wb_q, rt_id)));
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
  end

  // A taken branch discards the IF/ID instruction, so its hazard is moot.
  assign stall       = raw_hazard && !branch_taken;
  assign pc_write    = !stall;
  assign ifid_write  = !stall;
  assign idex_bubble = stall;
  assign flush_ifid  = branch_taken;
  assign flush_idex  = branch_taken;
  assign flush_exmem = branch_taken;
  assign stall_count = cnt_q;

  always_comb begin
    ex_d  = '{valid: 1'b1, dst: dst_id, wr: regwrite_id, load: memread_id,
              rs: rs_id, rt: rt_id};
    mem_d = ex_q;
    wb_d  = mem_q;
    if (branch_taken) begin
      ex_d  = SB_EMPTY;
      mem_d = SB_EMPTY;
    end else if (stall) begin
      ex_d  = SB_EMPTY;
    end

    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= SB_EMPTY;
      mem_q <= SB_EMPTY;
      wb_q  <= SB_EMPTY;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: three instances (forwarding, no forwarding,
// no forwarding with a 2-bit counter) driven in lockstep against a pipeline model.
module tb_hazard_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_id;
  logic [4:0]  dst_id;
  logic        regwrite_id, memread_id, branch_taken;

  logic pc_a, ifid_a, bub_a, fi_a, fx_a, fe_a;
  logic [1:0] fa_a, fb_a;
  logic [15:0] cnt_a;
  logic pc_b, ifid_b, bub_b, fi_b, fx_b, fe_b;
  logic [1:0] fa_b, fb_b;
  logic [15:0] cnt_b;
  logic pc_c, ifid_c, bub_c, fi_c, fx_c, fe_c;
  logic [1:0] fa_c, fb_c;
  logic [1:0] cnt_c;

  always #5 clk = ~clk;

  hazard_scheduler #(.FORWARDING(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .instr_id(instr_id), .dst_id(dst_id),
    .regwrite_id(regwrite_id), .memread_id(memread_id), .branch_taken(branch_taken),
    .pc_write(pc_a), .ifid_write(ifid_a), .idex_bubble(bub_a), .flush_ifid(fi_a),
    .flush_idex(fx_a), .flush_exmem(fe_a), .fwd_a(fa_a), .fwd_b(fb_a), .stall_count(cnt_a));

  hazard_scheduler #(.FORWARDING(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .instr_id(instr_id), .dst_id(dst_id),
    .regwrite_id(regwrite_id), .memread_id(memread_id), .branch_taken(branch_taken),
    .pc_write(pc_b), .ifid_write(ifid_b), .idex_bubble(bub_b), .flush_ifid(fi_b),
    .flush_idex(fx_b), .flush_exmem(fe_b), .fwd_a(fa_b), .fwd_b(fb_b), .stall_count(cnt_b));

  hazard_scheduler #(.FORWARDING(1'b0), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .instr_id(instr_id), .dst_id(dst_id),
    .regwrite_id(regwrite_id), .memread_id(memread_id), .branch_taken(branch_taken),
    .pc_write(pc_c), .ifid_write(ifid_c), .idex_bubble(bub_c), .flush_ifid(fi_c),
    .flush_idex(fx_c), .flush_exmem(fe_c), .fwd_a(fa_c), .fwd_b(fb_c), .stall_count(cnt_c));

  // Reference model: per configuration, the last three issued instructions by age
  // (0 = in EX, 1 = in MEM, 2 = in WB); a bubble is an invalid record.
  typedef struct {
    bit       v;
    bit [4:0] d;
    bit       w;
    bit       ld;
    bit [4:0] s;
    bit [4:0] t;
  } minst_t;

  minst_t hist [2][3];
  int     cnt_m [3];
  int     n_chk = 0;
  int     n_fail = 0;

  function automatic minst_t no_inst();
    minst_t e;
    e.v = 0; e.d = 0; e.w = 0; e.ld = 0; e.s = 0; e.t = 0;
    return e;
  endfunction

  function automatic bit produces(minst_t p, bit [4:0] r);
    return p.v && p.w && (p.d == r) && (r != 0);
  endfunction

  // Expected {pc, ifid, bubble, flush_ifid, flush_idex, flush_exmem, fwd_a, fwd_b}.
  function automatic bit [9:0] predict(int m);
    bit [4:0] src [2];
    bit       used [2];
    bit [1:0] sel [2];
    bit       need = 0;
    bit       stall;
    bit       fwd = (m == 0);
    src[0]  = instr_id[25:21];
    src[1]  = instr_id[20:16];
    used[0] = 1;
    used[1] = (instr_id[31:26] == 6'h00) || (instr_id[31:26] == 6'h2B) ||
              (instr_id[31:26] == 6'h04);
    for (int i = 0; i < 2; i++)
      if (used[i])
        for (int k = 0; k < 3; k++)
          if (produces(hist[m][k], src[i]) && (!fwd || (k == 0 && hist[m][0].ld)))
            need = 1;
    stall = need && !branch_taken;
    for (int i = 0; i < 2; i++) begin
      bit [4:0] opnd = (i == 0) ? hist[m][0].s : hist[m][0].t;
      sel[i] = 2'b00;
      if (fwd) begin
        if (produces(hist[m][1], opnd))      sel[i] = 2'b10;
        else if (produces(hist[m][2], opnd)) sel[i] = 2'b01;
      end
    end
    return {!stall, !stall, stall, branch_taken, branch_taken, branch_taken, sel[0], sel[1]};
  endfunction

  task automatic advance(int m, bit stall);
    minst_t n;
    n.v = 1; n.d = dst_id; n.w = regwrite_id; n.ld = memread_id;
    n.s = instr_id[25:21]; n.t = instr_id[20:16];
    hist[m][2] = hist[m][1];
    if (branch_taken) begin
      hist[m][1] = no_inst();
      hist[m][0] = no_inst();
    end else begin
      hist[m][1] = hist[m][0];
      hist[m][0] = stall ? no_inst() : n;
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 3; k++) hist[m][k] = no_inst();
    for (int c = 0; c < 3; c++) cnt_m[c] = 0;
  endtask

  task automatic check(string name, int unsigned got, int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic compare_models();
    check("fwd1_outputs", {22'd0, pc_a, ifid_a, bub_a, fi_a, fx_a, fe_a, fa_a, fb_a}, predict(0));
    check("fwd1_count", cnt_a, cnt_m[0]);
    check("fwd0_outputs", {22'd0, pc_b, ifid_b, bub_b, fi_b, fx_b, fe_b, fa_b, fb_b}, predict(1));
    check("fwd0_count", cnt_b, cnt_m[1]);
    check("cntw2_count", cnt_c, cnt_m[2]);
  endtask

  task automatic drive(bit [31:0] ins, bit [4:0] d, bit rw, bit mr, bit br);
    instr_id = ins; dst_id = d; regwrite_id = rw; memread_id = mr; branch_taken = br;
    #3;
    compare_models();
    $display("cycle t=%0t instr=%08h br=%0b | F1 bub=%0b fa=%0b fb=%0b cnt=%0d | F0 bub=%0b cnt=%0d",
             $time, ins, br, bub_a, fa_a, fb_a, cnt_a, bub_b, cnt_b);
  endtask

  task automatic tick();
    bit [9:0] p0, p1;
    p0 = predict(0);
    p1 = predict(1);
    @(posedge clk);
    advance(0, p0[7]);
    advance(1, p1[7]);
    if (p0[7]) cnt_m[0] = (cnt_m[0] == 65535) ? 65535 : cnt_m[0] + 1;
    if (p1[7]) cnt_m[1] = (cnt_m[1] == 65535) ? 65535 : cnt_m[1] + 1;
    if (p1[7]) cnt_m[2] = (cnt_m[2] == 3) ? 3 : cnt_m[2] + 1;
    #1;
  endtask

  task automatic do_reset();
    instr_id = 0; dst_id = 0; regwrite_id = 0; memread_id = 0; branch_taken = 0;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic bit [31:0] rtype(bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic bit [31:0] lw(bit [4:0] rs, bit [4:0] rt);
    return {6'h23, rs, rt, 16'd0};
  endfunction

  typedef struct {
    bit [31:0] ins;
    bit [4:0]  dst;
    bit        rw, mr, br;
    bit        bub;
    bit [1:0]  fa, fb;
    bit [15:0] cnt;
  } vec_t;

  vec_t vt [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ns;
    // lw/add load-use, add/sub forward from MEM, then register-0 pair.
    vt[0] = '{lw(0, 8),         8, 1, 1, 0, 0, 2'b00, 2'b00, 0};
    vt[1] = '{rtype(8, 8, 9),   9, 1, 0, 0, 1, 2'b00, 2'b00, 0};
    vt[2] = '{rtype(8, 8, 9),   9, 1, 0, 0, 0, 2'b00, 2'b00, 1};
    vt[3] = '{32'd0,            0, 0, 0, 0, 0, 2'b01, 2'b01, 1};
    vt[4] = '{rtype(1, 2, 8),   8, 1, 0, 0, 0, 2'b00, 2'b00, 1};
    vt[5] = '{rtype(8, 3, 9),   9, 1, 0, 0, 0, 2'b00, 2'b00, 1};
    vt[6] = '{32'd0,            0, 0, 0, 0, 0, 2'b10, 2'b00, 1};
    vt[7] = '{rtype(1, 2, 0),   0, 1, 0, 0, 0, 2'b00, 2'b00, 1};
    vt[8] = '{rtype(0, 0, 3),   3, 1, 0, 0, 0, 2'b00, 2'b00, 1};
    vt[9] = '{32'd0,            0, 0, 0, 0, 0, 2'b00, 2'b00, 1};

    instr_id = 0; dst_id = 0; regwrite_id = 0; memread_id = 0; branch_taken = 0;
    reset = 1'b0;
    #2;
    check("reset_outputs", {pc_a, ifid_a, bub_a, fi_a, fx_a, fe_a, fa_a, fb_a}, 10'b1100000000);
    check("reset_count", cnt_a, 0);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].ins, vt[i].dst, vt[i].rw, vt[i].mr, vt[i].br);
      check($sformatf("vec%0d", i), {bub_a, fa_a, fb_a, cnt_a},
            {vt[i].bub, vt[i].fa, vt[i].fb, vt[i].cnt});
      tick();
    end

    // Without forwarding: ALU-use stalls 3 cycles, then 2 with a 1-slot gap.
    do_reset();
    drive(rtype(1, 2, 8), 8, 1, 0, 0); tick();
    ns = 0;
    for (int i = 0; i < 8; i++) begin
      drive(rtype(8, 3, 9), 9, 1, 0, 0);
      if (!bub_b) break;
      ns++;
      tick();
    end
    check("fwd0_alu_use_len", ns, 3);
    check("fwd0_alu_use_count", cnt_b, 3);
    check("fwd1_alu_use_nostall", cnt_a, 0);
    tick();
    drive(rtype(1, 2, 8), 8, 1, 0, 0); tick();
    drive(rtype(4, 5, 10), 10, 1, 0, 0); tick();
    ns = 0;
    for (int i = 0; i < 8; i++) begin
      drive(rtype(8, 3, 9), 9, 1, 0, 0);
      if (!bub_b) break;
      ns++;
      tick();
    end
    check("fwd0_gap_len", ns, 2);
    check("fwd0_gap_count", cnt_b, 5);
    check("cntw2_saturated", cnt_c, 3);
    tick();

    // Taken branch on top of a load-use stall.
    do_reset();
    drive(lw(0, 8), 8, 1, 1, 0); tick();
    drive(rtype(8, 8, 9), 9, 1, 0, 1);
    check("branch_flush", {pc_a, ifid_a, bub_a, fi_a, fx_a, fe_a}, 6'b110111);
    tick();
    drive(rtype(8, 8, 9), 9, 1, 0, 0);
    check("post_branch_nostall", {bub_a, cnt_a}, 0);
    check("post_branch_fwd", {fa_a, fb_a}, 0);
    tick();

    // Reset asserted in the middle of a stall.
    do_reset();
    drive(lw(0, 8), 8, 1, 1, 0); tick();
    drive(rtype(8, 8, 9), 9, 1, 0, 0); tick();
    drive(rtype(8, 8, 9), 9, 1, 0, 0); tick();
    drive(lw(0, 8), 8, 1, 1, 0); tick();
    drive(rtype(8, 8, 9), 9, 1, 0, 0);
    check("pre_reset_stall", {bub_a, cnt_a}, {1'b1, 16'd1});
    reset = 1'b0;
    #1;
    model_reset();
    check("midstall_reset_outputs", {pc_a, ifid_a, bub_a, fi_a, fx_a, fe_a, fa_a, fb_a},
          10'b1100000000);
    check("midstall_reset_count", cnt_a, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(lw(0, 8), 8, 1, 1, 0); tick();
    ns = 0;
    for (int i = 0; i < 6; i++) begin
      drive(rtype(8, 8, 9), 9, 1, 0, 0);
      if (!bub_a) break;
      ns++;
      tick();
    end
    check("post_reset_loaduse_len", ns, 1);
    tick();

    // Random traffic over a small register set to provoke hazards.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit [5:0]  op;
      bit [4:0]  rs, rt, d;
      bit        rw, mr, br;
      int        sel = $urandom_range(0, 4);
      op = (sel == 0) ? 6'h00 : (sel == 1) ? 6'h23 : (sel == 2) ? 6'h2B :
           (sel == 3) ? 6'h04 : 6'h08;
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      d  = 5'($urandom_range(0, 3));
      rw = (op == 6'h2B || op == 6'h04) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 9) == 0) rw = ~rw;
      mr = (op == 6'h23);
      br = ($urandom_range(0, 15) == 0);
      drive({op, rs, rt, 16'h1234}, d, rw, mr, br);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
